line_xfer_ctrl: RTL
===================

LINE_XFER_CTRL -- requirements
Module: line_xfer_ctrl

Interface
REQ-001 SHALL have parameter RD_LAT, default 2: cycles from an accepted read to its valid mem_data_out.
REQ-002 SHALL have parameter ADDR_W, default 32: memory byte-address width.
REQ-003 SHALL have port clk, input, 1: single clock; all state on its rising edge.
REQ-004 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port req_valid, input, 1: line-transfer request.
REQ-006 SHALL have port req_ready, output, 1: block idle, request accepted this cycle if req_valid.
REQ-007 SHALL have port req_wr, input, 1: 1 = writeback of line, 0 = fill of line.
REQ-008 SHALL have port req_line_addr, input, ADDR_W-4: line address, byte address bits [ADDR_W-1:4].
REQ-009 SHALL have port wb_data, input, 128: writeback line, word i in bits [32i+31:32i].
REQ-010 SHALL have port fill_data, output, 128: assembled fill line, same word packing.
REQ-011 SHALL have port done, output, 1: one-cycle completion pulse.
REQ-012 SHALL have port err, output, 1: error flag for the transfer, valid with done.
REQ-013 SHALL have ports mem_addr (output, ADDR_W), mem_data_in (output, 32), mem_wr (output, 1), mem_rd (output, 1): word request to banked memory.
REQ-014 SHALL have ports mem_data_out (input, 32), mem_stall (input, 1), mem_err (input, 1): banked-memory responses.

Function
REQ-015 SHALL implement FSM IDLE -> ISSUE -> DRAIN -> DONE -> IDLE.
REQ-016 IDLE SHALL assert req_ready; on req_valid, capture req_wr, req_line_addr, wb_data and go to ISSUE next cycle.
REQ-017 ISSUE SHALL drive word index w = 0..3 in order, with mem_addr = {line_addr, w[1:0], 2'b00}, so word w targets bank w.
REQ-018 ISSUE SHALL drive mem_rd = ~req_wr or mem_wr = req_wr, never both, and mem_data_in = captured word w on writes.
REQ-019 A word SHALL count as accepted in a cycle with (mem_rd|mem_wr) & ~mem_stall; w advances only on acceptance.
REQ-020 While mem_stall is high, mem_addr, mem_data_in, mem_rd and mem_wr SHALL hold unchanged.
REQ-021 After word 3 is accepted, the next cycle SHALL enter DRAIN with mem_rd = mem_wr = 0.
REQ-022 Each accepted read SHALL push (valid, w) into an RD_LAT-deep pipe; mem_data_out SHALL be written into fill_data word w when that entry emerges.
REQ-023 DRAIN SHALL exit to DONE when the pipe is empty; for writes, DRAIN lasts exactly one cycle.
REQ-024 DONE SHALL pulse done for one cycle and present err; fill_data SHALL hold until the next fill completes.
REQ-025 err SHALL be sticky per transfer: set if mem_err is high in any accepted cycle; cleared on acceptance of a new request.
REQ-026 Throughput with no stalls SHALL be 1 word/cycle; a fill SHALL complete with done at cycle 4+RD_LAT+1 after acceptance.
REQ-027 req_valid outside IDLE SHALL be ignored (req_ready = 0).

Reset
REQ-028 rst SHALL immediately force IDLE and clear the read pipe, w and err.
REQ-029 During and after reset: req_ready = 1 (once rst is low), done = 0, err = 0, mem_rd = mem_wr = 0, mem_addr = 0, mem_data_in = 0, fill_data = 0.
REQ-030 Reset mid-transfer SHALL abandon the transfer silently, with no done pulse.

Configuration
REQ-031 Macro LINE_XFER_ERR_ABORT_EN defined: after the first accepted cycle with mem_err, no further words SHALL be issued; go to DRAIN, then DONE with err = 1.
REQ-032 Macro LINE_XFER_ERR_ABORT_EN undefined: all four words SHALL always be issued; err is only reported.

Structure
REQ-033 Package line_xfer_pkg SHALL hold the FSM state typedef, LINE_WORDS = 4, WORD_BYTES = 4 and the default RD_LAT.
REQ-034 The read-latency pipe SHALL be a sub-module rd_lat_pipe (valid plus 2-bit index shift register, depth RD_LAT).

Verification
REQ-035 Fill of line 0x0000010 with no stalls -> addresses 0x100, 0x104, 0x108 and 0x10C on consecutive cycles; fill_data equals memory words; done at cycle 7; err = 0.
REQ-036 Writeback of line 0x0000020, wb_data = 0x44443333_22221111_... -> four writes at 0x200..0x20C with matching data; done one cycle after the drain cycle.
REQ-037 Back-to-back fill immediately after a fill, with mem_stall high for 2 cycles on word 0 -> request held stable for 3 cycles, fill still correct.
REQ-038 mem_err high on word 2 -> with LINE_XFER_ERR_ABORT_EN, word 3 is never issued and err = 1; without it, all four words are issued and err = 1.
REQ-039 rst asserted during the ISSUE of word 1 -> mem_rd drops to 0 asynchronously, no done pulse, and the next request proceeds normally.

Source files
------------

// File: rtl/line_xfer_pkg.sv
// Shared types and constants for the line transfer controller.
package line_xfer_pkg;

    localparam int LINE_WORDS     = 4;
    localparam int WORD_BYTES     = 4;
    localparam int RD_LAT_DEFAULT = 2;
    localparam int LINE_BITS      = LINE_WORDS * 32;
    localparam int IDX_W          = $clog2(LINE_WORDS);
    localparam int WORD_OFF_W     = $clog2(WORD_BYTES);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } xfer_state_e;

    function automatic logic [31:0] line_word(input logic [LINE_BITS-1:0] line,
                                              input logic [IDX_W-1:0] idx);
        return line[{idx, 5'b00000} +: 32];
    endfunction

endpackage

// File: rtl/rd_lat_pipe.sv
// Read-latency tracker: shifts (valid, word index) pairs so each returning
// memory word can be steered into its slot of the fill line.
module rd_lat_pipe
    import line_xfer_pkg::*;
#(
    parameter int DEPTH = RD_LAT_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [IDX_W-1:0] idx_i,
    output logic             pop_valid_o,
    output logic [IDX_W-1:0] pop_idx_o,
    output logic             pending_o
);

    logic [DEPTH-1:0] vld_q;
    logic [IDX_W-1:0] idx_q [DEPTH];

    // Shift register of outstanding reads
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                idx_q[i] <= '0;
            end
        end else begin
            vld_q[0] <= push_i;
            idx_q[0] <= idx_i;
            for (int i = 1; i < DEPTH; i++) begin
                vld_q[i] <= vld_q[i-1];
                idx_q[i] <= idx_q[i-1];
            end
        end
    end

    assign pop_valid_o = vld_q[DEPTH-1];
    assign pop_idx_o   = idx_q[DEPTH-1];

    // Reads still in flight behind the one emerging this cycle
    always_comb begin
        pending_o = 1'b0;
        for (int i = 0; i < DEPTH - 1; i++) begin
            pending_o = pending_o | vld_q[i];
        end
    end

endmodule

// File: rtl/line_xfer_ctrl.sv
// Moves one 128-bit line to/from four-bank word memory, one word per cycle.
// Define LINE_XFER_ERR_ABORT_EN to stop issuing words after the first memory error.
module line_xfer_ctrl
    import line_xfer_pkg::*;
#(
    parameter int RD_LAT = RD_LAT_DEFAULT,
    parameter int ADDR_W = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_wr,
    input  logic [ADDR_W-5:0]    req_line_addr,
    input  logic [LINE_BITS-1:0] wb_data,
    output logic [LINE_BITS-1:0] fill_data,
    output logic                 done,
    output logic                 err,
    output logic [ADDR_W-1:0]    mem_addr,
    output logic [31:0]          mem_data_in,
    output logic                 mem_wr,
    output logic                 mem_rd,
    input  logic [31:0]          mem_data_out,
    input  logic                 mem_stall,
    input  logic                 mem_err
);

    xfer_state_e          state_q, state_d;
    logic [IDX_W-1:0]     w_q, w_d;
    logic                 wr_q, wr_d;
    logic [ADDR_W-5:0]    line_addr_q, line_addr_d;
    logic [LINE_BITS-1:0] wb_q, wb_d;
    logic [LINE_BITS-1:0] asm_q, asm_d;
    logic [LINE_BITS-1:0] fill_q, fill_d;
    logic                 err_q, err_d;

    logic             fire_s, accept_s, abort_s, last_s;
    logic             pop_valid_s, pending_s;
    logic [IDX_W-1:0] pop_idx_s;

    assign fire_s   = req_valid & (state_q == ST_IDLE);
    assign accept_s = (mem_rd | mem_wr) & ~mem_stall;
`ifdef LINE_XFER_ERR_ABORT_EN
    assign abort_s  = accept_s & mem_err;
`else
    assign abort_s  = 1'b0;
`endif
    assign last_s   = accept_s & ((w_q == 2'd3) | abort_s);

    rd_lat_pipe #(.DEPTH(RD_LAT)) u_rd_lat_pipe (
        .clk         (clk),
        .rst         (rst),
        .push_i      (accept_s & mem_rd),
        .idx_i       (w_q),
        .pop_valid_o (pop_valid_s),
        .pop_idx_o   (pop_idx_s),
        .pending_o   (pending_s)
    );

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  state_d = req_valid ? ST_ISSUE : ST_IDLE;
            ST_ISSUE: state_d = last_s ? ST_DRAIN : ST_ISSUE;
            ST_DRAIN: state_d = pending_s ? ST_DRAIN : ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Request capture, word counter and sticky error
    always_comb begin
        w_d         = w_q;
        wr_d        = wr_q;
        line_addr_d = line_addr_q;
        wb_d        = wb_q;
        err_d       = err_q;
        if (fire_s) begin
            w_d         = '0;
            wr_d        = req_wr;
            line_addr_d = req_line_addr;
            wb_d        = wb_data;
            err_d       = 1'b0;
        end else if (accept_s) begin
            w_d   = w_q + 2'd1;
            err_d = err_q | mem_err;
        end else begin
            w_d = w_q;
        end
    end

    // Fill assembly; the visible line only changes when a fill completes
    always_comb begin
        asm_d  = asm_q;
        fill_d = fill_q;
        if (fire_s) begin
            asm_d = '0;
        end else if (pop_valid_s) begin
            asm_d[{pop_idx_s, 5'b00000} +: 32] = mem_data_out;
        end else begin
            asm_d = asm_q;
        end
        if ((state_q == ST_DRAIN) && !pending_s && !wr_q) begin
            fill_d = asm_d;
        end else begin
            fill_d = fill_q;
        end
    end

    // Datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_q         <= '0;
            wr_q        <= 1'b0;
            line_addr_q <= '0;
            wb_q        <= '0;
            asm_q       <= '0;
            fill_q      <= '0;
            err_q       <= 1'b0;
        end else begin
            w_q         <= w_d;
            wr_q        <= wr_d;
            line_addr_q <= line_addr_d;
            wb_q        <= wb_d;
            asm_q       <= asm_d;
            fill_q      <= fill_d;
            err_q       <= err_d;
        end
    end

    // Outputs decoded from registered state only, so they hold while stalled
    always_comb begin
        req_ready = (state_q == ST_IDLE);
        done      = (state_q == ST_DONE);
        err       = err_q;
        fill_data = fill_q;
        if (state_q == ST_ISSUE) begin
            mem_rd      = ~wr_q;
            mem_wr      = wr_q;
            mem_addr    = {line_addr_q, w_q, {WORD_OFF_W{1'b0}}};
            mem_data_in = wr_q ? line_word(wb_q, w_q) : 32'h0000_0000;
        end else begin
            mem_rd      = 1'b0;
            mem_wr      = 1'b0;
            mem_addr    = '0;
            mem_data_in = 32'h0000_0000;
        end
    end

endmodule
